// File: rtl/imem_loader_if.sv
// Host byte channel into the program loader: one byte moves per cycle when
// in_valid and in_ready are both high.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes instruction RAM bytes on the fly, buffers
// label records until their checksum passes, and releases the core on 'E'.
module imem_loader #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LBL_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_loader_if.slave         host,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [7:0]           imem_wdata,
  output logic                 lbl_we,
  output logic [LBL_IDX_W-1:0] lbl_idx,
  output logic [15:0]          lbl_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 core_run
);

  typedef enum logic [3:0] {
    S_TYPE, S_I_LEN_H, S_I_LEN_L, S_I_ADR_H, S_I_ADR_L, S_I_DATA, S_I_CHK,
    S_L_IDX, S_L_VH, S_L_VL, S_L_CHK, S_DONE, S_ERR
  } state_t;

  state_t               state;
  logic                 armed;
  logic [7:0]           hold;
  logic [7:0]           sum;
  logic [15:0]          len_cnt;
  logic [ADDR_W-1:0]    addr;
  logic [LBL_IDX_W-1:0] idx_buf;
  logic [15:0]          val_buf;
  logic                 accept;
  logic [7:0]           sum_next;

  // armed keeps in_ready low while reset is held and until the first edge after release
  assign host.in_ready = armed && (state != S_DONE) && (state != S_ERR);
  assign accept        = host.in_valid && host.in_ready;
  assign sum_next      = sum + host.in_data;
  assign core_run      = done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_TYPE;
      armed      <= 1'b0;
      hold       <= '0;
      sum        <= '0;
      len_cnt    <= '0;
      addr       <= '0;
      idx_buf    <= '0;
      val_buf    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      lbl_we     <= 1'b0;
      lbl_idx    <= '0;
      lbl_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      armed   <= 1'b1;
      imem_we <= 1'b0;
      lbl_we  <= 1'b0;
      if (accept) begin
        sum <= sum_next;
        unique case (state)
          S_TYPE: begin
            sum <= '0;
            unique case (host.in_data)
              8'h49: begin state <= S_I_LEN_H; busy <= 1'b1; end
              8'h4C: begin state <= S_L_IDX;   busy <= 1'b1; end
              8'h45: begin state <= S_DONE;    done <= 1'b1; end
              default: begin state <= S_ERR;   err  <= 1'b1; end
            endcase
          end
          S_I_LEN_H: begin hold <= host.in_data; state <= S_I_LEN_L; end
          S_I_LEN_L: begin len_cnt <= {hold, host.in_data}; state <= S_I_ADR_H; end
          S_I_ADR_H: begin hold <= host.in_data; state <= S_I_ADR_L; end
          S_I_ADR_L: begin
            addr  <= ADDR_W'({hold, host.in_data});
            state <= (len_cnt == 16'd0) ? S_I_CHK : S_I_DATA;
          end
          S_I_DATA: begin
            imem_we    <= 1'b1;
            imem_addr  <= addr;
            imem_wdata <= host.in_data;
            addr       <= addr + ADDR_W'(1);
            len_cnt    <= len_cnt - 16'd1;
            if (len_cnt == 16'd1) state <= S_I_CHK;
          end
          S_L_IDX: begin
            idx_buf <= host.in_data[LBL_IDX_W-1:0];
            if (host.in_data[7:4] != 4'd0) begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_L_VH;
            end
          end
          S_L_VH: begin hold <= host.in_data; state <= S_L_VL; end
          S_L_VL: begin val_buf <= {hold, host.in_data}; state <= S_L_CHK; end
          S_I_CHK, S_L_CHK: begin
            busy <= 1'b0;
            if (sum_next == 8'd0) begin
              state <= S_TYPE;
              if (state == S_L_CHK) begin
                lbl_we    <= 1'b1;
                lbl_idx   <= idx_buf;
                lbl_wdata <= val_buf;
              end
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
